wta_inhibition_vote: RTL and testbench

- Sits directly downstream of the excitatory neuron array.
- Each cycle it consumes the out_spike bits of all excitatory neurons and produces their per-neuron inh inputs, giving lateral inhibition where a spike from any neuron inhibits all others.
- Over one encoding window it counts spikes per neuron, then runs a serial argmax scan and reports the winning neuron index for classification and labelling.

---
 rtl/wta_inhibition_vote_if.sv | 38 +++
 rtl/wta_inhibition_vote.sv | 157 +++++++++++++++
 tb/tb_wta_inhibition_vote.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wta_inhibition_vote_if.sv
// Bundle of the signals shared by the winner-take-all voter and its environment.
//   master : drives en/start/spikes and observes the results (the neuron-array side / bench)
//   slave  : the voter itself
// Signals:
//   en         global enable
//   start      one-cycle pulse that begins a sample window
//   spikes     out_spike bits of the excitatory neurons
//   inh        registered lateral inhibition back to each neuron
//   busy       high while counting or scanning
//   done       one-cycle pulse when winner is valid
//   winner     index of the neuron with the most spikes
//   winner_cnt spike count of the winner
//   no_spike   set together with winner when every count is zero
interface wta_inhibition_vote_if #(
  parameter int unsigned N_NEURON = 16,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned CNT_W    = 16
);
  logic                en;
  logic                start;
  logic [N_NEURON-1:0] spikes;
  logic [N_NEURON-1:0] inh;
  logic                busy;
  logic                done;
  logic [IDX_W-1:0]    winner;
  logic [CNT_W-1:0]    winner_cnt;
  logic                no_spike;

  modport master (
    output en, start, spikes,
    input  inh, busy, done, winner, winner_cnt, no_spike
  );

  modport slave (
    input  en, start, spikes,
    output inh, busy, done, winner, winner_cnt, no_spike
  );
endinterface

// File: rtl/wta_inhibition_vote.sv
// Winner-take-all voter placed directly after the excitatory neuron array.
// Each enabled cycle of a sample window it counts spikes per neuron and drives lateral
// inhibition (any spike inhibits every other neuron for INH_HOLD cycles). At the end of the
// window a serial argmax scan (one neuron per clock) picks the neuron with the most spikes,
// ties going to the lowest index.
// Ports:
//   clk  clock
//   rst  synchronous, active-high reset
//   bus  slave side of wta_inhibition_vote_if (en, start, spikes in; inh, busy, done,
//        winner, winner_cnt, no_spike out; all outputs registered)
module wta_inhibition_vote #(
  parameter int unsigned N_NEURON    = 16,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned ENCODE_TIME = 23,
  parameter int unsigned T_WINDOW    = 250,
  parameter int unsigned INH_HOLD    = 1
) (
  input logic                 clk,
  input logic                 rst,
  wta_inhibition_vote_if.slave bus
);

  localparam int unsigned WIN    = T_WINDOW * (ENCODE_TIME + 1);
  localparam int unsigned WIN_W  = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int unsigned HOLD_W = $clog2(INH_HOLD + 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StRun, StScan, StDone} state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q [N_NEURON];
  logic [WIN_W-1:0]    win_q;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [N_NEURON-1:0] mask_q, mask_d;
  logic [N_NEURON-1:0] inh_q, inh_d;
  logic [IDX_W-1:0]    scan_idx_q;
  logic [IDX_W-1:0]    best_idx_q;
  logic [CNT_W-1:0]    best_cnt_q;
  logic [CNT_W-1:0]    cnt_sel;
  logic                busy_q, done_q, no_spike_q;
  logic [IDX_W-1:0]    winner_q;
  logic [CNT_W-1:0]    winner_cnt_q;

  // Next hold/mask for an enabled RUN cycle; a new spike event always reloads.
  always_comb begin
    mask_d = mask_q;
    hold_d = hold_q;
    if (bus.spikes != '0) begin
      mask_d = bus.spikes;
      hold_d = HOLD_W'(INH_HOLD);
    end else if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end
  end

  // A neuron is inhibited when some *other* neuron is in the latched event mask.
  always_comb begin
    inh_d = '0;
    for (int i = 0; i < N_NEURON; i++) begin
      inh_d[i] = (hold_d != '0) && ((mask_d & ~(N_NEURON'(1) << i)) != '0);
    end
  end

  // Count of the neuron currently under the scan pointer.
  always_comb begin
    cnt_sel = '0;
    for (int i = 0; i < N_NEURON; i++) begin
      if (scan_idx_q == IDX_W'(i)) cnt_sel = cnt_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '{default: '0};
      win_q        <= '0;
      hold_q       <= '0;
      mask_q       <= '0;
      inh_q        <= '0;
      scan_idx_q   <= '0;
      best_idx_q   <= '0;
      best_cnt_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      winner_q     <= '0;
      winner_cnt_q <= '0;
      no_spike_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            cnt_q   <= '{default: '0};
            win_q   <= '0;
            hold_q  <= '0;
            mask_q  <= '0;
            inh_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (bus.en) begin
            for (int i = 0; i < N_NEURON; i++) begin
              if (bus.spikes[i] && (cnt_q[i] != CntMax)) cnt_q[i] <= cnt_q[i] + 1'b1;
            end
            if (win_q == WIN_W'(WIN - 1)) begin
              // Last window cycle: its spikes are still counted above.
              hold_q     <= '0;
              mask_q     <= '0;
              inh_q      <= '0;
              scan_idx_q <= '0;
              best_idx_q <= '0;
              best_cnt_q <= '0;
              state_q    <= StScan;
            end else begin
              win_q  <= win_q + 1'b1;
              hold_q <= hold_d;
              mask_q <= mask_d;
              inh_q  <= inh_d;
            end
          end
        end
        StScan: begin
          // Strict compare keeps the lowest index on ties.
          if (cnt_sel > best_cnt_q) begin
            best_idx_q <= scan_idx_q;
            best_cnt_q <= cnt_sel;
          end
          if (scan_idx_q == IDX_W'(N_NEURON - 1)) begin
            busy_q  <= 1'b0;
            state_q <= StDone;
          end else begin
            scan_idx_q <= scan_idx_q + 1'b1;
          end
        end
        StDone: begin
          done_q       <= 1'b1;
          winner_q     <= best_idx_q;
          winner_cnt_q <= best_cnt_q;
          no_spike_q   <= (best_cnt_q == '0);
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.inh        = inh_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.winner     = winner_q;
  assign bus.winner_cnt = winner_cnt_q;
  assign bus.no_spike   = no_spike_q;

endmodule

// File: tb/tb_wta_inhibition_vote.sv
// Bench for wta_inhibition_vote: table vectors, hand-written corner sequences and random
// windows, all compared cycle by cycle against a window-level reference model.
module tb_wta_inhibition_vote;
  localparam int unsigned N    = 4;
  localparam int unsigned IW   = 2;
  localparam int unsigned CW   = 8;
  localparam int unsigned CW2  = 2;
  localparam int unsigned ET   = 3;
  localparam int unsigned TW   = 2;
  localparam int unsigned HOLD = 2;
  localparam int unsigned WIN  = TW * (ET + 1);

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wta_inhibition_vote_if #(.N_NEURON(N), .IDX_W(IW), .CNT_W(CW))  bus ();
  wta_inhibition_vote_if #(.N_NEURON(N), .IDX_W(IW), .CNT_W(CW2)) bus2 ();

  assign bus2.en     = bus.en;
  assign bus2.start  = bus.start;
  assign bus2.spikes = bus.spikes;

  wta_inhibition_vote #(
    .N_NEURON(N), .IDX_W(IW), .CNT_W(CW), .ENCODE_TIME(ET), .T_WINDOW(TW), .INH_HOLD(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Narrow-counter copy to observe saturation.
  wta_inhibition_vote #(
    .N_NEURON(N), .IDX_W(IW), .CNT_W(CW2), .ENCODE_TIME(ET), .T_WINDOW(TW), .INH_HOLD(HOLD)
  ) dut_sat (
    .clk(clk),
    .rst(rst),
    .bus(bus2)
  );

  // Reference model: phase 0 idle, 1 counting, 2 waiting for the result.
  int          m_phase;
  int          m_steps;
  int          m_k;
  int          m_last_ev;
  logic [N-1:0] m_mask;
  int          m_cnt [N];
  logic [N-1:0] e_inh;
  logic        e_busy, e_done;
  int          e_win, e_wcnt, e_nos, e_win2, e_wcnt2, e_nos2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic argmax(input int cap, output int w, output int c);
    w = 0;
    c = 0;
    for (int j = 0; j < N; j++) begin
      int v;
      v = (m_cnt[j] > cap) ? cap : m_cnt[j];
      if (v > c) begin
        w = j;
        c = v;
      end
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_steps = 0; m_k = 0; m_last_ev = -1000; m_mask = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    e_inh = '0; e_busy = 1'b0; e_done = 1'b0;
    e_win = 0; e_wcnt = 0; e_nos = 0; e_win2 = 0; e_wcnt2 = 0; e_nos2 = 0;
  endtask

  task automatic model_edge(input bit en, input bit start, input logic [N-1:0] sp);
    logic [N-1:0] others;
    e_done = 1'b0;
    case (m_phase)
      0: if (start) begin
        m_phase = 1; m_steps = 0; m_last_ev = -1000; m_mask = '0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end
      1: if (en) begin
        for (int i = 0; i < N; i++) m_cnt[i] += int'(sp[i]);
        m_steps++;
        if (sp != '0) begin
          m_last_ev = m_steps;
          m_mask    = sp;
        end
        if (m_steps == WIN) begin
          m_phase = 2;
          m_k     = 0;
        end
      end
      default: begin
        m_k++;
        if (m_k == N + 1) begin
          argmax((1 << CW) - 1, e_win, e_wcnt);
          argmax((1 << CW2) - 1, e_win2, e_wcnt2);
          e_nos   = (e_wcnt == 0);
          e_nos2  = (e_wcnt2 == 0);
          e_done  = 1'b1;
          m_phase = 0;
        end
      end
    endcase
    e_busy = (m_phase == 1) || (m_phase == 2 && m_k < N);
    e_inh  = '0;
    if (m_phase == 1 && (m_steps - m_last_ev) < HOLD) begin
      for (int i = 0; i < N; i++) begin
        others    = m_mask;
        others[i] = 1'b0;
        e_inh[i]  = |others;
      end
    end
  endtask

  task automatic check_outputs();
    chk("inh", 32'(bus.inh), 32'(e_inh));
    chk("busy", 32'(bus.busy), 32'(e_busy));
    chk("done", 32'(bus.done), 32'(e_done));
    chk("winner", 32'(bus.winner), e_win);
    chk("winner_cnt", 32'(bus.winner_cnt), e_wcnt);
    chk("no_spike", 32'(bus.no_spike), e_nos);
    chk("sat_done", 32'(bus2.done), 32'(e_done));
    chk("sat_winner", 32'(bus2.winner), e_win2);
    chk("sat_winner_cnt", 32'(bus2.winner_cnt), e_wcnt2);
    chk("sat_no_spike", 32'(bus2.no_spike), e_nos2);
  endtask

  task automatic step(input bit en, input bit start, input logic [N-1:0] sp);
    bus.en     = en;
    bus.start  = start;
    bus.spikes = sp;
    @(posedge clk);
    model_edge(en, start, sp);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    bus.en     = 1'b0;
    bus.start  = 1'b0;
    bus.spikes = '0;
    @(posedge clk);
    model_reset();
    #1;
    check_outputs();
    rst = 1'b0;
  endtask

  // Steps with no input until done shows; lat = cycles after leaving RUN, 0 if never.
  task automatic drain(output int lat);
    lat = 0;
    for (int w = 1; w <= 12; w++) begin
      step(1'b1, 1'b0, '0);
      if (bus.done) begin
        lat = w;
        break;
      end
    end
  endtask

  typedef struct packed {
    logic [WIN-1:0][N-1:0] sp;
    logic [IW-1:0]         win;
    logic [CW-1:0]         wcnt;
    logic                  nos;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int lat;
    n_checks = 0;
    n_errors = 0;
    for (int t = 0; t < 4; t++) tbl[t] = '0;
    tbl[0].sp[0] = 4'b0001; tbl[0].sp[2] = 4'b0001; tbl[0].sp[5] = 4'b0100;
    tbl[0].win = 2'd0; tbl[0].wcnt = 8'd2; tbl[0].nos = 1'b0;
    tbl[1].win = 2'd0; tbl[1].wcnt = 8'd0; tbl[1].nos = 1'b1;
    tbl[2].sp[0] = 4'b1010; tbl[2].sp[3] = 4'b1010; tbl[2].sp[6] = 4'b1010;
    tbl[2].win = 2'd1; tbl[2].wcnt = 8'd3; tbl[2].nos = 1'b0;
    tbl[3].sp[1] = 4'b1000; tbl[3].sp[2] = 4'b1100; tbl[3].sp[4] = 4'b1000;
    tbl[3].sp[7] = 4'b0110;
    tbl[3].win = 2'd3; tbl[3].wcnt = 8'd3; tbl[3].nos = 1'b0;

    do_reset();
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_winner_cnt", 32'(bus.winner_cnt), 32'd0);

    // Table vectors.
    for (int t = 0; t < 4; t++) begin
      step(1'b1, 1'b1, '0);
      for (int c = 0; c < WIN; c++) begin
        step(1'b1, 1'b0, tbl[t].sp[c]);
        if (tbl[t].sp == '0) chk("tbl_quiet_inh", 32'(bus.inh), 32'd0);
      end
      drain(lat);
      chk("tbl_latency", lat, N + 1);
      chk("tbl_winner", 32'(bus.winner), 32'(tbl[t].win));
      chk("tbl_winner_cnt", 32'(bus.winner_cnt), 32'(tbl[t].wcnt));
      chk("tbl_no_spike", 32'(bus.no_spike), 32'(tbl[t].nos));
      step(1'b1, 1'b0, '0);
    end

    // Inhibition timing: pair at cycle 0, single neuron 2 at cycle 3.
    step(1'b1, 1'b1, '0);
    for (int c = 0; c < WIN; c++) begin
      case (c)
        0:       step(1'b1, 1'b0, 4'b1010);
        3:       step(1'b1, 1'b0, 4'b0100);
        default: step(1'b1, 1'b0, 4'b0000);
      endcase
      case (c)
        0, 1:    chk("inh_pair", 32'(bus.inh), 32'b1111);
        2:       chk("inh_pair_end", 32'(bus.inh), 32'd0);
        3, 4:    chk("inh_single", 32'(bus.inh), 32'b1011);
        5:       chk("inh_single_end", 32'(bus.inh), 32'd0);
        default: ;
      endcase
    end
    drain(lat);
    chk("inh_seq_latency", lat, N + 1);

    // en low for 5 cycles mid-window: counts and hold frozen, window stretched.
    step(1'b1, 1'b1, '0);
    step(1'b1, 1'b0, 4'b0010);
    step(1'b1, 1'b0, 4'b0010);
    chk("stall_inh_pre", 32'(bus.inh), 32'b1101);
    repeat (5) step(1'b0, 1'b0, 4'b1111);
    chk("stall_inh_frozen", 32'(bus.inh), 32'b1101);
    chk("stall_busy", 32'(bus.busy), 32'd1);
    step(1'b1, 1'b0, '0);
    chk("stall_inh_resume", 32'(bus.inh), 32'b1101);
    step(1'b1, 1'b0, '0);
    chk("stall_inh_end", 32'(bus.inh), 32'd0);
    repeat (4) step(1'b1, 1'b0, '0);
    drain(lat);
    chk("stall_latency", lat, N + 1);
    chk("stall_winner", 32'(bus.winner), 32'd1);
    chk("stall_winner_cnt", 32'(bus.winner_cnt), 32'd2);

    // Saturation on the 2-bit counter copy.
    step(1'b1, 1'b1, '0);
    for (int c = 0; c < WIN; c++) begin
      if (c < 5) step(1'b1, 1'b0, 4'b0100);
      else if (c == 5) step(1'b1, 1'b0, 4'b0001);
      else step(1'b1, 1'b0, '0);
    end
    drain(lat);
    chk("sat_wide_cnt", 32'(bus.winner_cnt), 32'd5);
    chk("sat_narrow_winner", 32'(bus2.winner), 32'd2);
    chk("sat_narrow_cnt", 32'(bus2.winner_cnt), 32'd3);

    // start pulse mid-RUN is ignored; window stays WIN long.
    step(1'b1, 1'b1, '0);
    for (int c = 0; c < WIN; c++) begin
      step(1'b1, (c == 2), (c == 4) ? 4'b1000 : 4'b0000);
    end
    drain(lat);
    chk("start_in_run_latency", lat, N + 1);
    chk("start_in_run_winner", 32'(bus.winner), 32'd3);

    // Reset during SCAN: no done, everything back to zero.
    step(1'b1, 1'b1, '0);
    for (int c = 0; c < WIN; c++) step(1'b1, 1'b0, (c == 1) ? 4'b0010 : 4'b0000);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    do_reset();
    chk("rst_scan_winner", 32'(bus.winner), 32'd0);
    chk("rst_scan_cnt", 32'(bus.winner_cnt), 32'd0);
    chk("rst_scan_busy", 32'(bus.busy), 32'd0);
    repeat (8) step(1'b1, 1'b0, '0);

    // Random windows against the model.
    for (int r = 0; r < 25; r++) begin
      int guard;
      repeat ($urandom_range(0, 3)) step(1'b1, 1'b0, N'($urandom));
      step(1'b1, 1'b1, '0);
      guard = 0;
      while (m_phase != 0 && guard < 200) begin
        step($urandom_range(0, 4) != 0, $urandom_range(0, 15) == 0,
             N'($urandom & $urandom & (($urandom_range(0, 1) != 0) ? 32'hF : 32'h4)));
        guard++;
      end
      if (guard >= 200) chk("rand_window_end", 32'(m_phase), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
